// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges un-stallable ALU results and FIFO-buffered load results onto one register-file write port.
// Optional starvation guard for queued loads is built when WB_STARVE_GUARD_EN is defined.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_d,
    output logic        wb_we,
    output logic [31:0] pend_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          wb_from_ld;

    logic          empty, alu_acc, alu_write, push_hs, push, pop, flow;
    logic          sel_we, sel_ld;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    // Handshakes: ALU request taken when alu_valid && !alu_stall; load taken when ld_valid && ld_ready at a rising edge.
    assign ld_ready = (count != FULL);

`ifdef WB_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    logic [WW-1:0] wait_cnt;

    assign alu_stall = (wait_cnt == WW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            wait_cnt <= '0;
        else if (pop)
            wait_cnt <= '0;
        else if (!empty && alu_write)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    logic unused_limit;
    assign unused_limit = (STARVE_LIMIT != 0);
    assign alu_stall    = 1'b0;
`endif

    always_comb begin
        empty     = (count == '0);
        alu_acc   = alu_valid && !alu_stall;
        alu_write = alu_acc && (alu_rd != 5'd0);
        push_hs   = ld_valid && ld_ready;
        pop       = 1'b0;
        flow      = 1'b0;
        sel_we    = 1'b0;
        sel_ld    = 1'b0;
        sel_rd    = q_rd[rd_ptr];
        sel_data  = q_data[rd_ptr];
        // A stall only ever happens with the FIFO non-empty, so the head is valid here.
        if (alu_stall) begin
            pop    = 1'b1;
            sel_we = 1'b1;
            sel_ld = 1'b1;
        end else if (alu_write) begin
            sel_we   = 1'b1;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (!empty) begin
            pop    = 1'b1;
            sel_we = 1'b1;
            sel_ld = 1'b1;
        end else if (push_hs && ld_rd != 5'd0) begin
            flow     = 1'b1;
            sel_we   = 1'b1;
            sel_ld   = 1'b1;
            sel_rd   = ld_rd;
            sel_data = ld_data;
        end
        push = push_hs && (ld_rd != 5'd0) && !flow;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= ld_rd;
            q_data[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            wb_addr    <= '0;
            wb_d       <= '0;
            wb_we      <= 1'b0;
            wb_from_ld <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wb_we      <= sel_we;
            wb_from_ld <= sel_ld;
            if (sel_we) begin
                wb_addr <= sel_rd;
                wb_d    <= sel_data;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count)
                pend_mask[q_rd[PW'(rd_ptr + PW'(i))]] = 1'b1;
        end
        if (wb_we && wb_from_ld)
            pend_mask[wb_addr] = 1'b1;
        pend_mask[0] = 1'b0;
    end

endmodule
